shift_share_arbiter: RTL and testbench
======================================

# shift_share_arbiter

Round-robin arbiter and sequencer that shares one N-bit left barrel shifter (result = data × 2^exp, truncated to N bits) among R requesters. Each requester presents an operand and shift amount with a valid/ready handshake. The block grants one request at a time, registers the operands, performs the shift, and returns the result tagged with the requester ID on a single valid/ready response port. It sits between the shift-using datapath clients and the shared shifter resource.

## Interface
- N, default 8: data width; must be ≥ 2.
- R, default 4: number of requesters; must be ≥ 2.
- clk  in  1: sole clock; all state changes on the rising edge.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  [R-1:0]: per-requester request valid.
- req_ready  out  [R-1:0]: per-requester accept; one-hot or zero.
- req_data  in  [R-1:0][N-1:0]: per-requester operand.
- req_exp  in  [R-1:0][$clog2(N)-1:0]: per-requester shift amount.
- rsp_valid  out  1: result valid.
- rsp_ready  in  1: consumer accepts the result.
- rsp_data  out  [N-1:0]: shifted result.
- rsp_id  out  [$clog2(R)-1:0]: index of the requester that owns rsp_data.
- rsp_ovf  out  1: overflow flag; present only when SHIFT_OVF_DETECT_EN is defined.

## Operation
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - When any req_valid is high, the round-robin winner gets req_ready=1 in that cycle (combinational from req_valid and the pointer).
  - The edge that completes the handshake captures req_data, req_exp and the winner index, updates last_grant to the winner, and moves to SHIFT.
  - With no requests, stay in IDLE and keep req_ready=0.
- Round-robin search starts at (last_grant+1) mod R and wraps. last_grant resets to R-1, so requester 0 has first priority after reset.
- SHIFT:
  - Compute captured_data << captured_exp, keep the low N bits, and register the result into rsp_data.
  - Set rsp_id to the captured index and move to RESP.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id stay stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE.
  - Without rsp_ready, hold indefinitely (backpressure).
- req_ready is 0 in SHIFT and RESP. No request is accepted while an operation is in flight.
- Arithmetic: the result equals (data × 2^exp) mod 2^N. Since exp ≤ N-1, bit 0 of the operand always survives into bit exp.
- A requester that deasserts req_valid before it is granted loses nothing. The arbiter never latches ungranted requests.
- Reset at any point aborts the in-flight operation with no response issued.

## Timing
- Reset values:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=R-1.
  - rsp_ovf=0 when present.
- Latency: accept edge at cycle k gives rsp_valid=1 in cycle k+2.
- Minimum issue interval is 3 cycles: accept, shift, response handshake. The next accept can occur in the cycle after the response handshake.
- req_ready depends combinationally on req_valid and registered state only. It has no combinational path from rsp_ready.
- rsp_valid, rsp_data, rsp_id and rsp_ovf are all register outputs.

## Configuration
- SHIFT_OVF_DETECT_EN defined:
  - rsp_ovf port exists.
  - In SHIFT, rsp_ovf is registered as 1 if any nonzero operand bit is shifted beyond bit N-1, i.e. captured_data[N-1 -: exp] ≠ 0 for exp > 0; otherwise 0.
  - rsp_ovf is held with rsp_data.
- SHIFT_OVF_DETECT_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Single request, N=8, R=4: req 0 with data=5, exp=2.
  - Required: req_ready[0] in the accept cycle, then rsp_valid two cycles later with rsp_data=20, rsp_id=0.
  - With the macro defined, rsp_ovf=0.
- Truncation/overflow: req 1 with data=5, exp=7.
  - Required: rsp_data=128, rsp_id=1.
  - With the macro: rsp_ovf=1. The same request with data=1, exp=7 gives rsp_data=128, rsp_ovf=0.
- Fairness: all four req_valid held high continuously, with rsp_ready=1.
  - Required: grant order 0,1,2,3,0,1…, with each grant 3 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - Required: rsp_data and rsp_id stable throughout.
  - Required: req_ready=0 on every port throughout.
  - Required: the response completes on the first cycle rsp_ready=1.
- Mid-operation reset: rst pulsed in SHIFT, and again in RESP.
  - Required: on the next cycle rsp_valid=0, rsp_data=0, state IDLE.
  - Required: the next grant goes to requester 0 when all requesters are valid.
- Zero cases: data=0, exp=2, and data=0xFF, exp=0.
  - Required: rsp_data=0 and 0xFF respectively.
  - With the macro: rsp_ovf=0 in both cases.

Source files
------------

// File: rtl/shift_share_arbiter.sv
// rtl/shift_share_arbiter.sv - round-robin arbiter sharing one left barrel shifter among R requesters
// Optional feature macro: SHIFT_OVF_DETECT_EN (adds the rsp_ovf overflow flag port and logic).
module shift_share_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [R-1:0]                  req_valid,
    output logic [R-1:0]                  req_ready,
    input  logic [R-1:0][N-1:0]           req_data,
    input  logic [R-1:0][$clog2(N)-1:0]   req_exp,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [N-1:0]                  rsp_data,
    output logic [$clog2(R)-1:0]          rsp_id
`ifdef SHIFT_OVF_DETECT_EN
    ,
    output logic                          rsp_ovf
`endif
);

    localparam int EW = $clog2(N);
    localparam int IW = $clog2(R);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    // Arbitration state: the pointer only moves on an accepted request.
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   winner;
    logic            any_req;
    logic            accept;

    // Operands of the single in-flight operation.
    logic [N-1:0]    cap_data;
    logic [EW-1:0]   cap_exp;
    logic [IW-1:0]   cap_id;

    // Shifter output, consumed only in SHIFT.
    logic [N-1:0]    shifted;
`ifdef SHIFT_OVF_DETECT_EN
    logic            ovf_next;
`endif

    // Round-robin search: first valid requester starting at last_grant+1, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = last_grant;
        any_req = 1'b0;
        for (int i = 1; i <= R; i++) begin
            idx = (int'(last_grant) + i) % R;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                winner  = idx[IW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant decode; req_ready only ever depends on req_valid and registers.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready[winner] = 1'b1;
                    accept            = 1'b1;
                    state_next        = SHIFT;
                end
            end
            SHIFT: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the granted operands and advance the round-robin pointer on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data   <= '0;
            cap_exp    <= '0;
            cap_id     <= '0;
            last_grant <= IW'(R - 1);
        end else if (accept) begin
            cap_data   <= req_data[winner];
            cap_exp    <= req_exp[winner];
            cap_id     <= winner;
            last_grant <= winner;
        end
    end

`ifdef SHIFT_OVF_DETECT_EN
    // Shift in a double-width field so bits pushed past N-1 remain visible for overflow.
    always_comb begin
        logic [2*N-1:0] wide;
        wide     = {{N{1'b0}}, cap_data} << cap_exp;
        shifted  = wide[N-1:0];
        ovf_next = |wide[2*N-1:N];
    end
`else
    // Shared left shifter; result is truncated to N bits.
    always_comb begin
        shifted = cap_data << cap_exp;
    end
`endif

    // Response registers: loaded in SHIFT, held through backpressure, valid dropped on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
`ifdef SHIFT_OVF_DETECT_EN
            rsp_ovf   <= 1'b0;
`endif
        end else if (state == SHIFT) begin
            rsp_valid <= 1'b1;
            rsp_data  <= shifted;
            rsp_id    <= cap_id;
`ifdef SHIFT_OVF_DETECT_EN
            rsp_ovf   <= ovf_next;
`endif
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_share_arbiter.sv
// tb/tb_shift_share_arbiter.sv - randomized self-checking bench for shift_share_arbiter
module tb_shift_share_arbiter;

    localparam int N  = 8;
    localparam int R  = 4;
    localparam int EW = $clog2(N);
    localparam int IW = $clog2(R);

    logic                 clk;
    logic                 rst;
    logic [R-1:0]         req_valid;
    logic [R-1:0]         req_ready;
    logic [R-1:0][N-1:0]  req_data;
    logic [R-1:0][EW-1:0] req_exp;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [N-1:0]         rsp_data;
    logic [IW-1:0]        rsp_id;
`ifdef SHIFT_OVF_DETECT_EN
    logic                 rsp_ovf;
`endif

    int checks = 0;
    int errors = 0;
    int model_last = R - 1;

    shift_share_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_exp   (req_exp),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef SHIFT_OVF_DETECT_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_result(input int d, input int e);
        return (d * (2 ** e)) % (2 ** N);
    endfunction

    function automatic bit model_ovf(input int d, input int e);
        return (d * (2 ** e)) >= (2 ** N);
    endfunction

    function automatic int rr_pick(input logic [R-1:0] mask);
        for (int i = 1; i <= R; i++) begin
            int idx;
            idx = (model_last + i) % R;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic run_txn(input string name, input logic [R-1:0] mask, input int stall);
        int            w;
        int            d;
        int            e;
        logic [R-1:0]  exp_rdy;
        logic [N-1:0]  exp_data;
        bit            exp_ovf;
        w        = rr_pick(mask);
        d        = int'(req_data[w]);
        e        = int'(req_exp[w]);
        exp_rdy  = '0;
        exp_rdy[w] = 1'b1;
        exp_data = N'(model_result(d, e));
        exp_ovf  = model_ovf(d, e);
        req_valid = mask;
        rsp_ready = (stall == 0);
        #1;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b expected %b", name, req_ready, exp_rdy);
        end
        tick();
        for (int r = 0; r < R; r++) begin
            req_data[r] = N'($urandom);
            req_exp[r]  = EW'($urandom);
        end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL %s shift_cycle: rsp_valid=%b req_ready=%b expected 0 and 0", name, rsp_valid, req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: rsp_valid=%b expected 1", name, rsp_valid);
        end
        checks++;
        if (rsp_data !== exp_data) begin
            errors++;
            $display("FAIL %s data: rsp_data=%0d expected %0d", name, rsp_data, exp_data);
        end
        checks++;
        if (rsp_id !== IW'(w)) begin
            errors++;
            $display("FAIL %s id: rsp_id=%0d expected %0d", name, rsp_id, w);
        end
`ifdef SHIFT_OVF_DETECT_EN
        checks++;
        if (rsp_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s ovf: rsp_ovf=%b expected %b", name, rsp_ovf, exp_ovf);
        end
`endif
        for (int s = 0; s < stall; s++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== IW'(w) || req_ready !== '0) begin
                errors++;
                $display("FAIL %s hold: valid=%b data=%0d id=%0d req_ready=%b expected 1 %0d %0d 0",
                         name, rsp_valid, rsp_data, rsp_id, req_ready, exp_data, w);
            end
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: rsp_valid=%b expected 0", name, rsp_valid);
        end
        model_last = w;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_data = '0;
        req_exp = '0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%0d id=%0d expected 0 0 0", rsp_valid, rsp_data, rsp_id);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL reset_idle_ready: req_ready=%b expected 0", req_ready);
        end
`ifdef SHIFT_OVF_DETECT_EN
        checks++;
        if (rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: rsp_ovf=%b expected 0", rsp_ovf);
        end
`endif
    endtask

    task automatic test_single();
        req_data[0] = 8'd5;
        req_exp[0]  = 3'd2;
        run_txn("single", 4'b0001, 0);
    endtask

    task automatic test_overflow();
        req_data[1] = 8'd5;
        req_exp[1]  = 3'd7;
        run_txn("ovf_5x7", 4'b0010, 0);
        req_data[1] = 8'd1;
        req_exp[1]  = 3'd7;
        run_txn("ovf_1x7", 4'b0010, 0);
    endtask

    task automatic test_zero();
        req_data[0] = 8'd0;
        req_exp[0]  = 3'd2;
        run_txn("zero_data", 4'b0001, 0);
        req_data[0] = 8'hFF;
        req_exp[0]  = 3'd0;
        run_txn("zero_exp", 4'b0001, 0);
    endtask

    task automatic test_backpressure();
        req_data[2] = 8'h3C;
        req_exp[2]  = 3'd3;
        run_txn("backpressure", 4'b0100, 10);
    endtask

    task automatic test_fairness();
        int           w;
        int           pending;
        logic [R-1:0] exp_rdy;
        for (int r = 0; r < R; r++) begin
            req_data[r] = N'(r + 1);
            req_exp[r]  = EW'(r);
        end
        w = rr_pick('1);
        pending = w;
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 24; c++) begin
            exp_rdy = '0;
            if (c % 3 == 0) exp_rdy[w] = 1'b1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL fairness_grant cycle %0d: req_ready=%b expected %b", c, req_ready, exp_rdy);
            end
            if (c % 3 == 0) begin
                pending = w;
                model_last = w;
                w = rr_pick('1);
            end
            if (c % 3 == 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== IW'(pending)) begin
                    errors++;
                    $display("FAIL fairness_rsp cycle %0d: valid=%b id=%0d expected 1 %0d", c, rsp_valid, rsp_id, pending);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_mid_reset();
        req_data[1] = 8'h11;
        req_exp[1]  = 3'd1;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_in_shift: valid=%b data=%0d expected 0 0", rsp_valid, rsp_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_shift_no_rsp: rsp_valid=%b expected 0", rsp_valid);
        end
        req_data[1] = 8'h11;
        req_exp[1]  = 3'd1;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h22) begin
            errors++;
            $display("FAIL pre_reset_resp: valid=%b data=%0d expected 1 34", rsp_valid, rsp_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_in_resp: valid=%b data=%0d expected 0 0", rsp_valid, rsp_data);
        end
        model_last = R - 1;
        for (int r = 0; r < R; r++) begin
            req_data[r] = N'($urandom);
            req_exp[r]  = EW'($urandom);
        end
        run_txn("post_reset", '1, 0);
    endtask

    task automatic test_random();
        logic [R-1:0] mask;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < R; r++) begin
                req_data[r] = N'($urandom);
                req_exp[r]  = EW'($urandom);
            end
            mask = R'($urandom_range(1, (1 << R) - 1));
            run_txn($sformatf("random%0d", it), mask, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_zero();
        test_backpressure();
        test_fairness();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
